// File: rtl/fpu_arb_pkg.sv
// Shared definitions for the fpu_adder round-robin arbiter: state encoding and
// the 32-bit float constants used when the watchdog substitutes a result.
package fpu_arb_pkg;

    localparam int FP_W = 32;
    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

endpackage

// File: rtl/fpu_adder_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request bit searching upward from
// last+1 (mod N_REQ); returns a one-hot grant, its index and an any-request flag.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        // Scan the farthest candidate first so the nearest one after last wins.
        for (int off = N_REQ; off >= 1; off--) begin
            if (req[(int'(last) + off) % N_REQ]) begin
                any = 1'b1;
                idx = IW'((int'(last) + off) % N_REQ);
            end
        end
        gnt = any ? (N_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/fpu_adder_arbiter.sv
// Shares one fpu_adder between N_REQ requesters with round-robin grants, one
// operation in flight at a time, and a watchdog that substitutes a quiet NaN.
module fpu_adder_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [FP_W*N_REQ-1:0] req_a,
    input  logic [FP_W*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      resp_valid,
    output logic [FP_W-1:0]       resp_z,
    output logic                  resp_err,
    output logic                  busy,
    output logic [FP_W-1:0]       adder_a,
    output logic [FP_W-1:0]       adder_b,
    output logic                  adder_a_stb,
    output logic                  adder_b_stb,
    input  logic [FP_W-1:0]       adder_z,
    input  logic                  adder_z_stb
);

    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      last_q, last_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [FP_W-1:0]    opa_q, opa_d;
    logic [FP_W-1:0]    opb_q, opb_d;
    logic               stb_q, stb_d;
    logic [N_REQ-1:0]   req_ready_q, req_ready_d;
    logic [N_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic [FP_W-1:0]    resp_z_q, resp_z_d;
    logic               resp_err_q, resp_err_d;
    logic               busy_q, busy_d;

    logic [N_REQ-1:0]   pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;

    rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_picker (
        .req  (req_valid),
        .last (last_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        gidx_d       = gidx_q;
        timer_d      = timer_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        stb_d        = stb_q;
        req_ready_d  = '0;
        resp_valid_d = '0;
        resp_z_d     = resp_z_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    opa_d       = req_a[int'(pick_idx)*FP_W +: FP_W];
                    opb_d       = req_b[int'(pick_idx)*FP_W +: FP_W];
                    stb_d       = 1'b1;
                    req_ready_d = pick_gnt;
                    last_d      = pick_idx;
                    gidx_d      = pick_idx;
                    timer_d     = '0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                // A real result takes precedence over a coincident timeout.
                if (adder_z_stb) begin
                    resp_z_d     = adder_z;
                    resp_err_d   = 1'b0;
                    resp_valid_d = N_REQ'(1) << gidx_q;
                    stb_d        = 1'b0;
                    timer_d      = '0;
                    state_d      = DRAIN;
                end else if (timer_q == T_LAST) begin
                    resp_z_d     = FP_QNAN;
                    resp_err_d   = 1'b1;
                    resp_valid_d = N_REQ'(1) << gidx_q;
                    stb_d        = 1'b0;
                    timer_d      = '0;
                    state_d      = DRAIN;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DRAIN: begin
                // Wait for the adder to drop its strobe, but never forever.
                if (!adder_z_stb || (timer_q == T_LAST)) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                stb_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_q       <= IW'(N_REQ - 1);
            gidx_q       <= '0;
            timer_q      <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            stb_q        <= 1'b0;
            req_ready_q  <= '0;
            resp_valid_q <= '0;
            resp_z_q     <= '0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            gidx_q       <= gidx_d;
            timer_q      <= timer_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            stb_q        <= stb_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_z_q     <= resp_z_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_z      = resp_z_q;
    assign resp_err    = resp_err_q;
    assign busy        = busy_q;
    assign adder_a     = opa_q;
    assign adder_b     = opb_q;
    assign adder_a_stb = stb_q;
    assign adder_b_stb = stb_q;

endmodule
